// File: rtl/mult_pkg.sv
// Shared constants for the iterative HI/LO multiplier.
// FSM encodings and operating-mode codes used by the multiplier and its step logic.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;

endpackage

// File: rtl/booth_step.sv
// One multiply iteration: Booth (signed) or add-shift (unsigned) add, then
// a single arithmetic right shift of {acc, q, q_m1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH+1:0] m,
  input  logic             signed_op,
  output logic [WIDTH+1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH+1:0] sum_s;

  // Select the add/subtract/no-op for this iteration.
  always_comb begin
    sum_s = acc;
    if (signed_op == MODE_SIGNED) begin
      case ({q[0], q_m1})
        2'b01:   sum_s = acc + m;
        2'b10:   sum_s = acc - m;
        default: sum_s = acc;
      endcase
    end else begin
      if (q[0]) begin
        sum_s = acc + m;
      end else begin
        sum_s = acc;
      end
    end
  end

  // Two guard bits keep the MSB a true sign, so replicating it is exact in both modes.
  assign acc_nxt  = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
  assign q_nxt    = {sum_s[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier for MULT/MULTU; one iteration per clock,
// product delivered on hi/lo with a one-cycle ready pulse.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH+1:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic             q_m1_r;
  logic [WIDTH+1:0] m_r;
  logic             sop_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             ready_r;
  logic             busy_r;

  logic             load_s;
  logic             last_s;
  logic [WIDTH+1:0] m_ext_s;
  logic [WIDTH+1:0] acc_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             q_m1_nxt_s;

  assign last_s  = (count_r == CNT_W'(WIDTH - 1));
  assign m_ext_s = (signed_op == MODE_SIGNED) ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_r),
    .q         (q_r),
    .q_m1      (q_m1_r),
    .m         (m_r),
    .signed_op (sop_r),
    .acc_nxt   (acc_nxt_s),
    .q_nxt     (q_nxt_s),
    .q_m1_nxt  (q_m1_nxt_s)
  );

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and the registered status flags derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s == ST_RUN);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      acc_r   <= '0;
      q_r     <= '0;
      q_m1_r  <= 1'b0;
      m_r     <= '0;
      sop_r   <= MODE_UNSIGNED;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (load_s) begin
      count_r <= '0;
      acc_r   <= '0;
      q_r     <= b;
      q_m1_r  <= 1'b0;
      m_r     <= m_ext_s;
      sop_r   <= signed_op;
    end else if (state_r == ST_RUN) begin
      acc_r  <= acc_nxt_s;
      q_r    <= q_nxt_s;
      q_m1_r <= q_m1_nxt_s;
      if (last_s) begin
        hi_r <= acc_nxt_s[WIDTH-1:0];
        lo_r <= q_nxt_s;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign hi    = hi_r;
  assign lo    = lo_r;
  assign ready = ready_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised self-checking bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start32, sop32, ready32, busy32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sop8, ready8, busy8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .signed_op(sop32),
    .a(a32), .b(b32), .hi(hi32), .lo(lo32), .ready(ready32), .busy(busy32)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_op(sop8),
    .a(a8), .b(b8), .hi(hi8), .lo(lo8), .ready(ready8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: full-width product, taken modulo 2^(2W).
  function automatic logic [63:0] ref32(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  function automatic logic [15:0] ref8(input bit s, input logic [7:0] x, input logic [7:0] y);
    int xi, yi;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    return 16'(xi * yi);
  endfunction

  task automatic run32(input bit s, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    start32 = 1'b1; sop32 = s; a32 = x; b32 = y;
    @(posedge clk);
    #1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom; sop32 = ~s;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready32) break;
    end
    res = {hi32, lo32};
  endtask

  task automatic run8(input bit s, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    start8 = 1'b1; sop8 = s; a8 = x; b8 = y;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sop8 = ~s;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready8) break;
    end
    res = {hi8, lo8};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, first;
    logic [15:0] r8, held8;
    int lat, pulses, cyc, nready, t1, t2, busy_err;
    bit s;
    logic [7:0] x8, y8;

    reset_n = 1'b0;
    start32 = 1'b0; sop32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    start8  = 1'b0; sop8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_hilo32", {hi32, lo32}, 64'd0);
    check("rst_flags32", {62'd0, ready32, busy32}, 64'd0);
    check("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
    check("rst_flags8", {62'd0, ready8, busy8}, 64'd0);
    reset_n = 1'b1;

    // Signed -1 * 2, with latency, DONE-cycle busy and hold-after-ready.
    run32(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, res, lat);
    check("s_m1x2", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check("s_m1x2_lat", 64'(lat), 64'd32);
    check("done_busy", {63'd0, busy32}, 64'd0);
    @(negedge clk);
    check("ready_pulse_1cyc", {63'd0, ready32}, 64'd0);
    check("hold_after", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset mid-run clears everything at once and emits no ready.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b0; a32 = 32'd5; b32 = 32'd7;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy", {63'd0, busy32}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_hilo", {hi32, lo32}, 64'd0);
    check("midrst_flags", {62'd0, ready32, busy32}, 64'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready32) pulses++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready32) pulses++;
    end
    check("midrst_noready", 64'(pulses), 64'd0);
    run32(1'b0, 32'd5, 32'd7, res, lat);
    check("post_rst_5x7", res, 64'd35);
    check("post_rst_lat", 64'(lat), 64'd32);

    run32(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, res, lat);
    check("u_ffx2", res, 64'h0000_0001_FFFF_FFFE);
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("s_min_min", res, 64'h4000_0000_0000_0000);
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("u_max_max", res, 64'hFFFF_FFFE_0000_0001);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y;
      s = 1'($urandom);
      x = $urandom; y = $urandom;
      run32(s, x, y, res, lat);
      check("rand32", res, ref32(s, x, y));
    end

    // start pulsed during RUN with other operands is ignored.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 start32 = 1'b0;
    pulses = 0; first = 64'd0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start32 = 1'b1; sop32 = 1'b0; a32 = 32'd3; b32 = 32'd9;
      end else begin
        start32 = 1'b0;
      end
      if (ready32) begin
        pulses++;
        if (pulses == 1) first = {hi32, lo32};
      end
    end
    check("ignore_start_res", first, ref32(1'b1, 32'h1234_5678, 32'h9ABC_DEF0));
    check("ignore_start_pulses", 64'(pulses), 64'd1);

    // start held high: back-to-back results, operand changes during RUN ignored.
    @(negedge clk);
    start32 = 1'b1; sop32 = 1'b1; a32 = 32'd3; b32 = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 a32 = 32'd7; b32 = 32'd6;
    cyc = 0; nready = 0; t1 = 0; t2 = 0; busy_err = 0;
    while (cyc < 120 && nready < 2) begin
      @(negedge clk);
      cyc++;
      if (busy32 == ready32) busy_err++;
      if (ready32) begin
        nready++;
        if (nready == 1) begin
          t1 = cyc;
          check("b2b_first", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF4);
          #1 a32 = 32'd1; b32 = 32'd1;
          a32 = 32'd7; b32 = 32'd6;
        end else begin
          t2 = cyc;
          start32 = 1'b0;
          check("b2b_second", {hi32, lo32}, 64'd42);
        end
      end
    end
    check("b2b_count", 64'(nready), 64'd2);
    check("b2b_gap", 64'(t2 - t1), 64'd33);
    check("b2b_busy_pattern", 64'(busy_err), 64'd0);

    // WIDTH=8 randomised sweep with corner cases first.
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
      if (i == 0) begin s = 1'b1; x8 = 8'h80; y8 = 8'h80; end
      if (i == 1) begin s = 1'b0; x8 = 8'hFF; y8 = 8'hFF; end
      if (i == 2) begin s = 1'b1; x8 = 8'h7F; y8 = 8'h80; end
      if (i == 3) begin s = 1'b1; x8 = 8'h00; y8 = 8'hFF; end
      run8(s, x8, y8, r8, lat);
      check("w8_prod", {48'd0, r8}, {48'd0, ref8(s, x8, y8)});
      check("w8_lat", 64'(lat), 64'd8);
      held8 = r8;
      @(negedge clk);
      check("w8_hold", {47'd0, ready8, hi8, lo8}, {48'd0, held8});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
